// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the external memory bus arbiter.
// Holds the FSM state enum, the latched request bundle and the ROM boundary default.
package bus_pkg;

    localparam logic [31:0] DEF_ROM_TOP = 32'h0000_1000;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        ACK
    } bus_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_req_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and external-bus signals of the memory bus arbiter.
// Requester: req/we/m_addr/m_wdata/m_be in, ack/err/rdata out.
// External bus: address/data_out/AS_L/WE_L/BE_L/ROM_Select out, data_in/DTACK_L in.
// The master modport is the arbiter view; slave is the environment view.
interface mem_bus_arbiter_if #(
    parameter int NUM_MASTERS = 3
);

    logic [NUM_MASTERS-1:0]       req;
    logic [NUM_MASTERS-1:0]       we;
    logic [NUM_MASTERS-1:0][31:0] m_addr;
    logic [NUM_MASTERS-1:0][31:0] m_wdata;
    logic [NUM_MASTERS-1:0][3:0]  m_be;
    logic [NUM_MASTERS-1:0]       ack;
    logic                         err;
    logic [31:0]                  rdata;

    logic [31:0] address;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        AS_L;
    logic        WE_L;
    logic [3:0]  BE_L;
    logic        DTACK_L;
    logic        ROM_Select;

    modport master (
        input  req, we, m_addr, m_wdata, m_be,
        input  data_in, DTACK_L,
        output ack, err, rdata,
        output address, data_out, AS_L, WE_L, BE_L, ROM_Select
    );

    modport slave (
        output req, we, m_addr, m_wdata, m_be,
        output data_in, DTACK_L,
        input  ack, err, rdata,
        input  address, data_out, AS_L, WE_L, BE_L, ROM_Select
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational grant logic: master 0 has absolute priority, the rest round-robin.
// Ports: i_req (requests), i_ptr (first non-zero index to try), o_gnt (one-hot), o_idx.
module rr_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int IW          = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IW-1:0]          i_ptr,
    output logic [NUM_MASTERS-1:0] o_gnt,
    output logic [IW-1:0]          o_idx
);

    logic w_found;

    always_comb begin
        int k;
        k       = 0;
        w_found = 1'b0;
        o_gnt   = '0;
        o_idx   = '0;
        if (i_req[0]) begin
            o_gnt[0] = 1'b1;
        end else begin
            // Walk 1..N-1 starting at the pointer, wrapping past index 0.
            for (int i = 0; i < NUM_MASTERS - 1; i++) begin
                k = (int'(i_ptr) - 1 + i) % (NUM_MASTERS - 1) + 1;
                if (!w_found && i_req[k]) begin
                    w_found  = 1'b1;
                    o_gnt[k] = 1'b1;
                    o_idx    = IW'(k);
                end
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one asynchronous-handshake memory bus (AS_L/WE_L/DTACK_L) among requesters.
// Ports: CLOCK_50, RESET (async, active-high), mbus (mem_bus_arbiter_if.master).
// Optional BUS_TIMEOUT_EN adds a watchdog that ends a stalled cycle with err=1.
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter int          NUM_MASTERS    = 3,
    parameter logic [31:0] ROM_TOP        = DEF_ROM_TOP,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    mem_bus_arbiter_if.master     mbus
);

    localparam int IW = $clog2(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_chk
        $error("mem_bus_arbiter: parameter out of range");
    end

    bus_state_t             r_state;
    bus_state_t             w_next;
    logic                   w_load;
    logic                   w_done;
    logic                   w_tout;
    logic                   w_tmo_hit;

    logic [NUM_MASTERS-1:0] w_gnt;
    logic [IW-1:0]          w_idx;
    bus_req_t               w_sel;

    logic [NUM_MASTERS-1:0] r_gnt;
    logic [IW-1:0]          r_win;
    logic [IW-1:0]          r_ptr;
    logic [31:0]            r_addr;
    logic [31:0]            r_wdata;
    logic [31:0]            r_rdata;
    logic                   r_as_l;
    logic                   r_we_l;
    logic [3:0]             r_be_l;
    logic [NUM_MASTERS-1:0] r_ack;

    rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS),
        .IW          (IW)
    ) u_rr (
        .i_req (mbus.req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    always_comb begin
        w_sel.we    = mbus.we[w_idx];
        w_sel.addr  = mbus.m_addr[w_idx];
        w_sel.wdata = mbus.m_wdata[w_idx];
        w_sel.be    = mbus.m_be[w_idx];
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_err;

    // Counts BUS cycles; zero in the first BUS cycle.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= '0;
        end else if (r_state == BUS && !w_tmo_hit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_tmo_hit = (r_cnt == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_done && w_tout;
        end
    end

    assign mbus.err = r_err;
`else
    assign w_tmo_hit = 1'b0;
    assign mbus.err  = 1'b0;
`endif

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_done = 1'b0;
        w_tout = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (|mbus.req) begin
                    w_load = 1'b1;
                    w_next = BUS;
                end
            end
            BUS: begin
                if (!mbus.DTACK_L) begin
                    w_done = 1'b1;
                    w_next = ACK;
                end else if (w_tmo_hit) begin
                    w_done = 1'b1;
                    w_tout = 1'b1;
                    w_next = ACK;
                end
            end
            ACK: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_gnt   <= '0;
            r_win   <= '0;
            r_ptr   <= IW'(1);
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_as_l  <= 1'b1;
            r_we_l  <= 1'b1;
            r_be_l  <= 4'hF;
            r_ack   <= '0;
        end else begin
            r_ack <= '0;
            if (w_load) begin
                r_gnt   <= w_gnt;
                r_win   <= w_idx;
                r_addr  <= w_sel.addr;
                r_wdata <= w_sel.wdata;
                r_as_l  <= 1'b0;
                r_we_l  <= ~w_sel.we;
                r_be_l  <= ~w_sel.be;
            end
            if (w_done) begin
                r_as_l  <= 1'b1;
                r_we_l  <= 1'b1;
                r_be_l  <= 4'hF;
                r_ack   <= r_gnt;
                r_rdata <= w_tout ? 32'h0 : mbus.data_in;
            end
            // The loader never moves the pointer, so it cannot starve 1..N-1 order.
            if (r_state == ACK && r_win != '0) begin
                if (r_win == IW'(NUM_MASTERS - 1)) begin
                    r_ptr <= IW'(1);
                end else begin
                    r_ptr <= r_win + 1'b1;
                end
            end
        end
    end

    assign mbus.ack        = r_ack;
    assign mbus.rdata      = r_rdata;
    assign mbus.address    = r_addr;
    assign mbus.data_out   = r_wdata;
    assign mbus.AS_L       = r_as_l;
    assign mbus.WE_L       = r_we_l;
    assign mbus.BE_L       = r_be_l;
    assign mbus.ROM_Select = (r_addr < ROM_TOP);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: vector table for single transfers,
// hand sequences for reset abort, loader priority, round-robin and timeout.
module tb_mem_bus_arbiter;

    localparam int NM  = 3;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst;
    int   n_run  = 0;
    int   n_fail = 0;

    mem_bus_arbiter_if #(.NUM_MASTERS(NM)) bus ();

    mem_bus_arbiter #(
        .NUM_MASTERS    (NM),
        .ROM_TOP        (32'h0000_1000),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .mbus     (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] din;
        int          n;
        logic        rom;
        logic [3:0]  be_l;
        logic        we_l;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.req     = '0;
        bus.we      = '0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.m_be    = '0;
        bus.data_in = 32'h0;
        bus.DTACK_L = 1'b1;
    endtask

    task automatic set_master(input int m, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] be);
        bus.we[m]      = w;
        bus.m_addr[m]  = a;
        bus.m_wdata[m] = d;
        bus.m_be[m]    = be;
        bus.req[m]     = 1'b1;
    endtask

    // Polls on falling edges until some ack shows up or the budget runs out.
    task automatic wait_ack(input int budget, output logic [NM-1:0] a,
                            output int cyc);
        cyc = 0;
        a   = '0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus.ack != '0) begin
                a = bus.ack;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [NM-1:0] e;
        e = '0;
        e[v.m] = 1'b1;
        bus.DTACK_L = 1'b1;
        bus.data_in = 32'hBAD0_BAD0;
        set_master(v.m, v.we, v.addr, v.wdata, v.be);
        @(negedge clk);
        chk("bus_as_l", 32'(bus.AS_L), 32'd0);
        chk("bus_we_l", 32'(bus.WE_L), 32'(v.we_l));
        chk("bus_be_l", 32'(bus.BE_L), 32'(v.be_l));
        chk("bus_addr", bus.address, v.addr);
        chk("rom_sel", 32'(bus.ROM_Select), 32'(v.rom));
        if (v.we) chk("bus_wdata", bus.data_out, v.wdata);
        for (int i = 0; i < v.n; i++) begin
            @(negedge clk);
            chk("wait_as_l", 32'(bus.AS_L), 32'd0);
            chk("wait_we_l", 32'(bus.WE_L), 32'(v.we_l));
            chk("wait_no_ack", 32'(bus.ack), 32'd0);
        end
        bus.DTACK_L = 1'b0;
        bus.data_in = v.din;
        @(negedge clk);
        bus.DTACK_L = 1'b1;
        chk("ack_onehot", 32'(bus.ack), 32'(e));
        chk("rdata", bus.rdata, v.din);
        chk("err_clear", 32'(bus.err), 32'd0);
        chk("ack_as_l", 32'(bus.AS_L), 32'd1);
        bus.req[v.m] = 1'b0;
        @(negedge clk);
        chk("ack_pulse_end", 32'(bus.ack), 32'd0);
    endtask

    initial begin
        logic [NM-1:0] a;
        int            c;
        logic [NM-1:0] prio_exp[5];
        logic [NM-1:0] rr_exp[4];
        vec_t          pre;

        vecs[0] = '{2, 1'b0, 32'h0000_0208, 32'h0, 4'hF, 32'h00C0_0093,
                    0, 1'b1, 4'h0, 1'b1};
        vecs[1] = '{1, 1'b1, 32'h0000_2000, 32'hAABB_CCDD, 4'b0011, 32'h5A5A_5A5A,
                    5, 1'b0, 4'b1100, 1'b0};
        vecs[2] = '{0, 1'b1, 32'h0000_0FFC, 32'h1234_5678, 4'hF, 32'hCAFE_F00D,
                    1, 1'b1, 4'h0, 1'b0};
        vecs[3] = '{1, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 32'hDEAD_BEEF,
                    2, 1'b0, 4'h0, 1'b1};
        vecs[4] = '{2, 1'b1, 32'hFFFF_FFFC, 32'h0BAD_F00D, 4'b1000, 32'h0,
                    0, 1'b0, 4'b0111, 1'b0};
        pre     = '{1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 32'h1111_1111,
                    0, 1'b1, 4'h0, 1'b1};
        prio_exp = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b100};
        rr_exp   = '{3'b010, 3'b100, 3'b010, 3'b100};

        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_as_l", 32'(bus.AS_L), 32'd1);
        chk("rst_we_l", 32'(bus.WE_L), 32'd1);
        chk("rst_be_l", 32'(bus.BE_L), 32'hF);
        chk("rst_addr", bus.address, 32'h0);
        chk("rst_dout", bus.data_out, 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset mid-cycle: move the pointer to 2 first, then abort a read.
        run_vec(pre);
        set_master(1, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
        @(negedge clk);
        chk("mid_bus_as_l", 32'(bus.AS_L), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_as_l", 32'(bus.AS_L), 32'd1);
        chk("mid_rst_ack", 32'(bus.ack), 32'd0);
        bus.req = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_no_ack", 32'(bus.ack), 32'd0);
        end
        bus.DTACK_L = 1'b0;
        bus.data_in = 32'h2222_2222;
        set_master(1, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
        set_master(2, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
        wait_ack(10, a, c);
        chk("mid_ptr_reset", 32'(a), 32'(3'b010));
        bus.req = '0;
        @(negedge clk);

        // Loader priority from a fresh pointer.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_master(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
        set_master(1, 1'b0, 32'h0000_0110, 32'h0, 4'hF);
        set_master(2, 1'b0, 32'h0000_0210, 32'h0, 4'hF);
        for (int j = 0; j < 5; j++) begin
            wait_ack(10, a, c);
            chk("prio_order", 32'(a), 32'(prio_exp[j]));
            if (j > 0) chk("prio_spacing", 32'(c), 32'd3);
            if (j == 2) bus.req[0] = 1'b0;
            if (j == 3) bus.req[1] = 1'b0;
            if (j == 4) bus.req[2] = 1'b0;
        end
        @(negedge clk);

        // Round-robin between 1 and 2 with a one-cycle idle gap.
        set_master(1, 1'b0, 32'h0000_0120, 32'h0, 4'hF);
        set_master(2, 1'b0, 32'h0000_0220, 32'h0, 4'hF);
        for (int j = 0; j < 4; j++) begin
            wait_ack(10, a, c);
            chk("rr_order", 32'(a), 32'(rr_exp[j]));
            chk("rr_latency", 32'(c), 32'd2);
            @(negedge clk);
            chk("rr_idle_as_l", 32'(bus.AS_L), 32'd1);
            chk("rr_idle_ack", 32'(bus.ack), 32'd0);
        end
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);

        // Stalled slave.
        bus.DTACK_L = 1'b1;
        bus.data_in = 32'h3333_3333;
        set_master(1, 1'b0, 32'h0000_3000, 32'h0, 4'hF);
`ifdef BUS_TIMEOUT_EN
        wait_ack(TMO + 10, a, c);
        chk("tmo_ack", 32'(a), 32'(3'b010));
        chk("tmo_latency", 32'(c), 32'(TMO + 2));
        chk("tmo_err", 32'(bus.err), 32'd1);
        chk("tmo_rdata", bus.rdata, 32'h0);
        bus.req = '0;
        @(negedge clk);
        chk("tmo_err_clear", 32'(bus.err), 32'd0);
`else
        wait_ack(200, a, c);
        chk("no_tmo_ack", 32'(a), 32'd0);
        chk("no_tmo_as_l", 32'(bus.AS_L), 32'd0);
        bus.req = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
